// File: rtl/int_seq_ctrl.sv
// int_seq_ctrl: 6502 interrupt sequencer that synchronises RES/NMI/IRQ pins and freezes one decision per instruction boundary
// Ports:
//   clk, rst (async, active-high)   core clock and reset
//   sync                            core at opcode fetch (instruction boundary)
//   res_n, nmi_n, irq_n[NUM_IRQ]    active-low asynchronous interrupt pins
//   i_flag                          processor I bit, masks IRQ when 1
//   ack                             core entered the vector fetch for int_kind
//   int_req, int_kind, vector,      frozen decision handed to the BRK/int microsequence
//   irq_src                         winning IRQ line index (valid for int_kind=01)
module int_seq_ctrl #(
   parameter int NUM_IRQ     = 4,
   parameter int SYNC_STAGES = 2,
   parameter int SRC_W       = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sync,
   input  logic               res_n,
   input  logic               nmi_n,
   input  logic [NUM_IRQ-1:0] irq_n,
   input  logic               i_flag,
   input  logic               ack,
   output logic               int_req,
   output logic [1:0]         int_kind,
   output logic [15:0]        vector,
   output logic [SRC_W-1:0]   irq_src
);
   typedef enum logic {IDLE, HELD} state_t;
   localparam int W = NUM_IRQ + 2;
   logic [W-1:0] sync_q [SYNC_STAGES];
   logic res_s, nmi_s;
   logic [NUM_IRQ-1:0] irq_s;
   logic nmi_prev_q, nmi_pend_q, res_pend_q;
   state_t state_q;
   logic nmi_edge, irq_act, take_ack, res_ack, nmi_ack;
   logic [1:0] dec_kind;
   logic [15:0] dec_vec;
   logic [SRC_W-1:0] src_d;
   assign {res_s, nmi_s, irq_s} = sync_q[SYNC_STAGES-1];
   assign nmi_edge = nmi_prev_q & ~nmi_s;
   assign irq_act  = ~i_flag & |(~irq_s);
   // A held RES overrides the frozen decision, so ack only counts with RES released
   assign take_ack = (state_q == HELD) & ack & res_s;
   assign res_ack  = take_ack & (int_kind == 2'b11);
   assign nmi_ack  = take_ack & (int_kind == 2'b10);
   assign dec_kind = res_pend_q ? 2'b11 : nmi_pend_q ? 2'b10 : 2'b01;
   assign dec_vec  = res_pend_q ? 16'hFFFC : nmi_pend_q ? 16'hFFFA : 16'hFFFE;
   // Lowest-index asserted line wins: scan from the top so lower indices overwrite
   always_comb begin
      src_d = '0;
      for (int k = NUM_IRQ - 1; k >= 0; k--)
         if (!irq_s[k]) src_d = SRC_W'(k);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '1;
         nmi_prev_q <= 1'b1;
         nmi_pend_q <= 1'b0;
         res_pend_q <= 1'b1;
         state_q    <= HELD;
         int_req    <= 1'b1;
         int_kind   <= 2'b11;
         vector     <= 16'hFFFC;
         irq_src    <= '0;
      end else begin
         sync_q[0] <= {res_n, nmi_n, irq_n};
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         nmi_prev_q <= nmi_s;
         // A new edge in the ack cycle keeps the NMI pending
         nmi_pend_q <= nmi_edge | (nmi_pend_q & ~nmi_ack);
         res_pend_q <= ~res_s | (res_pend_q & ~res_ack);
         if (state_q == HELD) begin
            if (!res_s) begin
               int_kind <= 2'b11;
               vector   <= 16'hFFFC;
               irq_src  <= '0;
            end else if (ack) begin
               state_q  <= IDLE;
               int_req  <= 1'b0;
               int_kind <= 2'b00;
               vector   <= 16'h0000;
               irq_src  <= '0;
            end
         end else if (sync && (res_pend_q || nmi_pend_q || irq_act)) begin
            state_q  <= HELD;
            int_req  <= 1'b1;
            int_kind <= dec_kind;
            vector   <= dec_vec;
            irq_src  <= (dec_kind == 2'b01) ? src_d : '0;
         end
      end
   end
endmodule

// File: tb/tb_int_seq_ctrl.sv
// tb_int_seq_ctrl: directed checks of the interrupt sequencer
module tb_int_seq_ctrl;
   logic clk = 1'b0;
   logic rst, sync, res_n, nmi_n, i_flag, ack;
   logic [3:0] irq_n;
   logic int_req;
   logic [1:0] int_kind;
   logic [15:0] vector;
   logic [3:0] irq_src;
   int passed = 0;
   int total = 0;
   int nmi_seen = 0;
   int_seq_ctrl #(.NUM_IRQ(4), .SYNC_STAGES(2), .SRC_W(4)) dut (
      .clk(clk), .rst(rst), .sync(sync), .res_n(res_n), .nmi_n(nmi_n),
      .irq_n(irq_n), .i_flag(i_flag), .ack(ack),
      .int_req(int_req), .int_kind(int_kind), .vector(vector), .irq_src(irq_src)
   );
   always #5 clk = ~clk;
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask
   task automatic chk_out(input string tag, input logic req, input logic [1:0] kind,
                          input logic [15:0] vec, input logic [3:0] src);
      chk({tag, ".req"}, 32'(int_req), 32'(req));
      chk({tag, ".kind"}, 32'(int_kind), 32'(kind));
      chk({tag, ".vec"}, 32'(vector), 32'(vec));
      chk({tag, ".src"}, 32'(irq_src), 32'(src));
   endtask
   task automatic pulse_sync();
      sync = 1'b1;
      tick();
      sync = 1'b0;
   endtask
   task automatic pulse_ack();
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask
   initial begin
      rst = 1'b1; sync = 1'b0; res_n = 1'b1; nmi_n = 1'b1;
      irq_n = 4'hF; i_flag = 1'b1; ack = 1'b0;
      tick(2);
      chk_out("reset", 1'b1, 2'b11, 16'hFFFC, 4'd0);
      // 1: reset sequence after release
      rst = 1'b0;
      tick(3);
      chk_out("post_rst", 1'b1, 2'b11, 16'hFFFC, 4'd0);
      pulse_sync();
      chk_out("held_sync_ignored", 1'b1, 2'b11, 16'hFFFC, 4'd0);
      pulse_ack();
      chk_out("res_ack", 1'b0, 2'b00, 16'h0000, 4'd0);
      pulse_sync();
      chk_out("idle_none", 1'b0, 2'b00, 16'h0000, 4'd0);
      pulse_ack();
      chk_out("idle_ack_ignored", 1'b0, 2'b00, 16'h0000, 4'd0);
      // 2: NMI held low for ~50 cycles yields exactly one request
      nmi_n = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick(3);
         pulse_sync();
         if (int_req) begin
            nmi_seen++;
            chk("nmi_vec", 32'(vector), 32'hFFFA);
            pulse_ack();
         end
      end
      chk("nmi_count", 32'(nmi_seen), 32'd1);
      nmi_n = 1'b1;
      tick(4);
      // 3: IRQ lines 0 and 2, unmasked then masked
      irq_n = 4'b1010; i_flag = 1'b0;
      tick(4);
      pulse_sync();
      chk_out("irq_l0", 1'b1, 2'b01, 16'hFFFE, 4'd0);
      pulse_ack();
      chk_out("irq_ack", 1'b0, 2'b00, 16'h0000, 4'd0);
      i_flag = 1'b1;
      pulse_sync();
      chk_out("irq_masked", 1'b0, 2'b00, 16'h0000, 4'd0);
      irq_n = 4'b0111; i_flag = 1'b0;
      tick(4);
      pulse_sync();
      chk_out("irq_l3", 1'b1, 2'b01, 16'hFFFE, 4'd3);
      pulse_ack();
      irq_n = 4'hF;
      tick(4);
      // 4: NMI and IRQ together, NMI first then IRQ
      irq_n = 4'b1011; nmi_n = 1'b0;
      tick(4);
      pulse_sync();
      chk_out("nmi_over_irq", 1'b1, 2'b10, 16'hFFFA, 4'd0);
      pulse_ack();
      pulse_sync();
      chk_out("irq_after_nmi", 1'b1, 2'b01, 16'hFFFE, 4'd2);
      irq_n = 4'hF; nmi_n = 1'b1;
      pulse_ack();
      tick(4);
      // 5: NMI edge coincident with IRQ ack stays pending
      irq_n = 4'b1110;
      tick(4);
      pulse_sync();
      chk_out("irq_l0_b", 1'b1, 2'b01, 16'hFFFE, 4'd0);
      nmi_n = 1'b0;
      tick(2);
      pulse_ack();
      chk_out("ack_with_edge", 1'b0, 2'b00, 16'h0000, 4'd0);
      irq_n = 4'hF; i_flag = 1'b1;
      tick();
      pulse_sync();
      chk_out("nmi_kept", 1'b1, 2'b10, 16'hFFFA, 4'd0);
      pulse_ack();
      nmi_n = 1'b1;
      tick(4);
      // 6: async reset while HELD with IRQ
      irq_n = 4'b1101; i_flag = 1'b0;
      tick(4);
      pulse_sync();
      chk_out("irq_l1", 1'b1, 2'b01, 16'hFFFE, 4'd1);
      #2 rst = 1'b1;
      #1;
      chk_out("async_rst", 1'b1, 2'b11, 16'hFFFC, 4'd0);
      rst = 1'b0;
      tick();
      pulse_ack();
      chk_out("rst_ack", 1'b0, 2'b00, 16'h0000, 4'd0);
      // RES pin overrides a held IRQ decision and blocks ack while low
      pulse_sync();
      chk_out("irq_l1_b", 1'b1, 2'b01, 16'hFFFE, 4'd1);
      res_n = 1'b0;
      tick(3);
      chk_out("res_override", 1'b1, 2'b11, 16'hFFFC, 4'd0);
      pulse_ack();
      chk_out("ack_res_held", 1'b1, 2'b11, 16'hFFFC, 4'd0);
      res_n = 1'b1; irq_n = 4'hF; i_flag = 1'b1;
      tick(3);
      pulse_ack();
      chk_out("res_released_ack", 1'b0, 2'b00, 16'h0000, 4'd0);
      pulse_sync();
      chk_out("final_idle", 1'b0, 2'b00, 16'h0000, 4'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
